// File: rtl/ppa_pipe.sv
// ppa_pipe -- pipelined Kogge-Stone parallel-prefix adder/subtractor.
//
// Computes A+B+cin (in_sub=0) or A-B (in_sub=1) with a registered prefix
// tree. LVL_PER_ST prefix levels are evaluated between pipeline registers.
// Latency is 1+NST cycles, where NST = ceil(log2(WIDTH)/LVL_PER_ST).
// Throughput is one beat per cycle. A valid/ready handshake provides
// backpressure: the whole pipe freezes while the output is stalled.
//
// Optional feature (macro PPA_PIPE_SAT_EN):
//   When this macro is defined, a signed overflow makes the output stage
//   saturate to the signed min/max value, and forces the carry bit to 0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_a, in_b            operands (WIDTH)
//   in_cin                carry-in (ignored when in_sub=1)
//   in_sub                1: A-B, 0: A+B+cin
//   in_tag                sideband tag (TAG_W)
//   out_valid/out_ready   output handshake
//   out_sum               {carry_out, sum} (WIDTH+1)
//   out_ovf               two's-complement overflow
//   out_tag               tag of this result

// One prefix level: bit i merges with bit i-DIST.
module ppa_lvl #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    if (i >= DIST) begin : gen_op
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
      assign p_o[i] = p_i[i] & p_i[i-DIST];
    end else begin : gen_pass
      // The group already reaches bit -1 (c0), so g is final here.
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end
endmodule

module ppa_pipe #(
  parameter int WIDTH      = 16,
  parameter int LVL_PER_ST = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NST    = (LEVELS + LVL_PER_ST - 1) / LVL_PER_ST;

  // vld_pipe[0] is stage 0, vld_pipe[NST] is the output register.
  logic [NST:0] vld_pipe;
  logic         stall;

  // Stage s register holds the prefix state that enters stage s+1.
  logic [NST-1:0][WIDTH-1:0] g_q, p_q, x_q;
  logic [NST-1:0][TAG_W-1:0] tag_q;
  logic [NST-1:0]            c0_q, am_q;

  // Combinational outputs of the prefix levels of each stage.
  logic [NST-1:0][WIDTH-1:0] g_st, p_st;

  logic [WIDTH:0]   out_sum_q;
  logic             out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  // Input-side operand conditioning.
  logic [WIDTH-1:0] b_d, p_d, g_d;
  logic             c0_d;

  assign b_d  = in_sub ? ~in_b : in_b;
  assign c0_d = in_sub | in_cin;
  assign p_d  = in_a ^ b_d;
  // Fold the carry-in in as a generate at bit -1, so bit 0 sees it.
  assign g_d  = (in_a & b_d) | {{(WIDTH-1){1'b0}}, p_d[0] & c0_d};

  assign stall     = vld_pipe[NST] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[NST];
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

  // The prefix tree. Levels beyond LEVELS (last stage only) pass through.
  for (genvar s = 0; s < NST; s++) begin : gen_st
    for (genvar j = 0; j < LVL_PER_ST; j++) begin : gen_lv
      logic [WIDTH-1:0] gi, pi, go, po;
      if (j == 0) begin : gen_src_reg
        assign gi = g_q[s];
        assign pi = p_q[s];
      end else begin : gen_src_lv
        assign gi = gen_lv[j-1].go;
        assign pi = gen_lv[j-1].po;
      end
      if (s*LVL_PER_ST + j < LEVELS) begin : gen_op
        ppa_lvl #(
          .WIDTH(WIDTH),
          .DIST (1 << (s*LVL_PER_ST + j))
        ) u_lvl (
          .g_i(gi),
          .p_i(pi),
          .g_o(go),
          .p_o(po)
        );
      end else begin : gen_pass
        assign go = gi;
        assign po = pi;
      end
    end
    assign g_st[s] = gen_lv[LVL_PER_ST-1].go;
    assign p_st[s] = gen_lv[LVL_PER_ST-1].po;
  end

  // Sum formation on the final stage's group generates (= bit carries).
  logic [WIDTH-1:0] gf, sraw;
  logic             cout, cmsb, ovf_d;
  logic [WIDTH:0]   sum_d;

  assign gf    = g_st[NST-1];
  assign sraw  = x_q[NST-1] ^ {gf[WIDTH-2:0], c0_q[NST-1]};
  assign cout  = gf[WIDTH-1];
  assign cmsb  = gf[WIDTH-2];
  assign ovf_d = cout ^ cmsb;

`ifdef PPA_PIPE_SAT_EN
  // An overflow can only occur when the operands have the same sign, so
  // the sign of A gives the direction in which to saturate.
  always_comb begin
    sum_d = {cout, sraw};
    if (ovf_d) begin
      sum_d = am_q[NST-1] ? {2'b01, {(WIDTH-1){1'b0}}}
                          : {2'b00, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_d = {cout, sraw};
`endif

  // The final stage's group-propagate is not needed. The A sign bit is
  // used only when saturation is on.
  logic unused_sink;
  assign unused_sink = ^{p_st[NST-1], am_q[NST-1]};

  // All stages advance together, unless the output is stalled. Bubbles
  // advance with them and are never collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      g_q       <= '0;
      p_q       <= '0;
      x_q       <= '0;
      tag_q     <= '0;
      c0_q      <= '0;
      am_q      <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      out_tag_q <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[NST-1:0], in_valid};
      g_q[0]   <= g_d;
      p_q[0]   <= p_d;
      x_q[0]   <= p_d;
      tag_q[0] <= in_tag;
      c0_q[0]  <= c0_d;
      am_q[0]  <= in_a[WIDTH-1];
      for (int s = 1; s < NST; s++) begin
        g_q[s]   <= g_st[s-1];
        p_q[s]   <= p_st[s-1];
        x_q[s]   <= x_q[s-1];
        tag_q[s] <= tag_q[s-1];
        c0_q[s]  <= c0_q[s-1];
        am_q[s]  <= am_q[s-1];
      end
      out_sum_q <= sum_d;
      out_ovf_q <= ovf_d;
      out_tag_q <= tag_q[NST-1];
    end
  end
endmodule

// File: tb/tb_ppa_pipe.sv
// Directed bench for ppa_pipe (WIDTH=16, LVL_PER_ST=2, TAG_W=4).
module tb_ppa_pipe;
  localparam int W  = 16;
  localparam int TW = 4;
`ifdef PPA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready, out_ovf;
  logic [W:0]    out_sum;

  always #5 clk = ~clk;

  ppa_pipe #(.WIDTH(W), .LVL_PER_ST(2), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_tag  (out_tag)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  a, b;
    logic          cin, sub;
    logic [TW-1:0] tag;
    logic [W:0]    sum;   // raw wrap-around result
    logic          ovf;
  } vec_t;

  vec_t tbl[14];

  // Apply saturation to a raw expected value when that build is selected.
  function automatic logic [W:0] exp_sum(input logic [W:0] raw, input logic ovf, input logic amsb);
    if (SAT && ovf) return amsb ? 17'h08000 : 17'h07FFF;
    return raw;
  endfunction

  // Plain-arithmetic reference: returns {ovf, carry, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         o;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    o  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {o, s};
  endfunction

  // Present one beat and check its latency and result. The task is entered
  // and left 1 time unit after a rising edge.
  task automatic run_one(input vec_t v, input string nm);
    int n;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_tag = v.tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 12);
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_sum"}, out_sum, exp_sum(v.sum, v.ovf, v.a[W-1]));
    chk({nm, "_ovf"}, out_ovf, v.ovf);
    chk({nm, "_tag"}, out_tag, v.tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W:0]    bp_sum[8];
    logic          bp_ovf[8];
    logic [W+1:0]  m;
    logic [W-1:0]  ba[8], bb[8];
    int c, sent, got;

    //       a         b         cin   sub   tag   sum        ovf
    tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 4'h5, 17'h05555, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'h1, 17'h10000, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, 17'h08000, 1'b1};
    tbl[3]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 4'h3, 17'h0FFFE, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 4'h4, 17'h17FFF, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0, 17'h00000, 1'b0};
    tbl[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'hF, 17'h1FFFF, 1'b0};
    tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 4'h7, 17'h10000, 1'b1};
    tbl[8]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 4'h8, 17'h10002, 1'b0};
    tbl[9]  = '{16'h1000, 16'h1000, 1'b1, 1'b1, 4'h9, 17'h10000, 1'b0};
    tbl[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 4'hA, 17'h0FFFF, 1'b1};
    tbl[11] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 4'hB, 17'h10000, 1'b0};
    tbl[12] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 4'hC, 17'h08000, 1'b1};
    tbl[13] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 4'hD, 17'h05556, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 14; i++) run_one(tbl[i], $sformatf("vec%0d", i));
    @(posedge clk); #1;
    chk("vec_drained", out_valid, 0);

    // Backpressure: 8 beats; downstream not ready in cycles 4..9.
    for (int i = 0; i < 8; i++) begin
      ba[i] = 16'(16'h0123 + 16'h1111 * i);
      bb[i] = 16'(16'h0F0F * (i + 1));
      m = model(ba[i], bb[i], i[0], (i == 3 || i == 6));
      bp_ovf[i] = m[W+1];
      bp_sum[i] = exp_sum(m[W:0], m[W+1], ba[i][W-1]);
    end
    c = 0; sent = 0; got = 0;
    while (got < 8 && c < 60) begin
      out_ready = !(c >= 4 && c <= 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = ba[sent]; in_b = bb[sent]; in_cin = sent[0];
        in_sub = (sent == 3 || sent == 6); in_tag = TW'(sent);
      end
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, !(c >= 4 && c <= 9));
      if (out_valid) begin
        chk($sformatf("bp_tag_c%0d", c), out_tag, got);
        chk($sformatf("bp_sum_c%0d", c), out_sum, bp_sum[got]);
        chk($sformatf("bp_ovf_c%0d", c), out_ovf, bp_ovf[got]);
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_got", got, 8);
    chk("bp_sent", sent, 8);
    #1;
    chk("bp_drained", out_valid, 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1111; in_b = 16'(i); in_cin = 1'b0; in_sub = 1'b0;
      in_tag = TW'(9 + i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_stale%0d", i), out_valid, 0);
    end
    run_one(tbl[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
